multi_stream_output_writer: RTL and testbench
=============================================

// Module: multi_stream_output_writer
// PURPOSE
// - Successor to the single-config output writer: N_STREAMS normalized AXI4S output streams, each chunked into host-write transfers.
// - Each stream fills a host buffer (base vaddr + capacity). Buffers are rearmed per packet or on capacity exhaustion.
// - Issues one sq_wr request per chunk, round-robin arbitrated. Tracks outstanding cq_wr completions per stream (bounded).
// - Emits one notify per packet carrying the total byte count. Sits between the operator pipeline and the shell queues.
// PARAMETERS
// N_STREAMS        4     number of independent streams (>=1)
// DATA_W           512   tdata width in bits; KEEP_W = DATA_W/8
// TRANSFER_BYTES   4096  max bytes per chunk; power of two, multiple of KEEP_W
// MAX_OUTSTANDING  8     max issued-but-uncompleted requests per stream (power of two)
// SID_W            $clog2(N_STREAMS) (min 1)
// PORTS
// clk            in   1               clock
// rst_n          in   1               synchronous active-low reset
// cfg_valid      in   N               per-stream buffer config valid
// cfg_ready      out  N               per-stream buffer config accept
// cfg_vaddr      in   N*48            buffer base virtual address
// cfg_bytes      in   N*32            buffer capacity in bytes, multiple of KEEP_W, >0
// in_tdata       in   N*DATA_W        input stream data
// in_tkeep       in   N*KEEP_W        keep: all ones except on tlast beat (LSB-contiguous)
// in_tlast       in   N               packet end
// in_tvalid      in   N               input valid
// in_tready      out  N               input ready
// out_tdata      out  N*DATA_W       per-stream data toward the host
// out_tkeep      out  N*KEEP_W       forwarded keep
// out_tlast      out  N               high on the last beat of each chunk
// out_tvalid     out  N               output valid
// out_tready     in   N               output ready
// sq_valid       out  1               write request valid
// sq_ready       in   1               write request accept
// sq_vaddr       out  48              chunk start address
// sq_len         out  28              chunk length in bytes
// sq_strm        out  SID_W           requesting stream
// sq_last        out  1               chunk ends a packet
// cq_valid       in   1               completion valid (always accepted)
// cq_strm        in   SID_W           completing stream
// notify_valid   out  1               packet-done notify valid
// notify_ready   in   1               notify accept
// notify_strm    out  SID_W           notifying stream
// notify_bytes   out  32              total packet bytes
// BEHAVIOUR
// - Reset: all FSMs go to IDLE; counters and RR pointers clear to 0. All valid/ready outputs are 0; data outputs are 0.
// - Per-stream FSM: IDLE -> STREAM -> REQ -> (STREAM | REARM | DRAIN) ; DRAIN -> NOTIFY -> IDLE.
//   - IDLE: cfg_ready=1. A cfg handshake loads addr=cfg_vaddr, cap=cfg_bytes, clears chunk and total counters, then goes to STREAM.
//   - STREAM: in->out combinational pass-through: out_tvalid=in_tvalid, in_tready=out_tready, data/keep unmodified.
//     - Chunk ends on the first beat where chunk_bytes+popcount(keep) == TRANSFER_BYTES, or == remaining cap, or tlast.
//     - out_tlast=1 on that beat. The transfer moves the FSM to REQ.
//     - in_tready=0 while outstanding == MAX_OUTSTANDING and chunk_bytes == 0.
//   - REQ: requests RR arbiter; in_tready=0. On sq handshake: addr+=len, cap-=len, total+=len, outstanding++, chunk clears.
//     - Next state is DRAIN if sq_last, else REARM if cap==0, else STREAM.
//   - REARM: cfg_ready=1. A new cfg loads addr/cap; total is kept. Goes to STREAM.
//   - DRAIN: waits for outstanding==0, then goes to NOTIFY.
//   - NOTIFY: requests notify RR arbiter with total. On handshake goes to IDLE.
// - sq/notify arbiters: independent round-robin. Grant is held while valid&&!ready. Pointer advances to grant+1 on handshake.
//   - A stream gets at most one grant per cycle.
// - cq: cq_valid decrements outstanding[cq_strm]. Same-cycle issue and completion on one stream nets 0.
//   - cq to a stream with outstanding==0 is ignored; the sim assert fires.
// - Counters: popcount over KEEP_W. total saturates at 2^32-1. sq_len <= TRANSFER_BYTES always.
// - Assertions: non-last keep all ones; last keep LSB-contiguous; cfg_bytes nonzero and KEEP_W-aligned.
// - rst_n low mid-packet: all state is discarded in the next cycle. No request or notify is emitted for the partial packet.
// TESTING
// - N=1, cfg(0x1000,64KiB), 128 full 64B beats + tlast -> 2 sq (0x1000/4096, 0x2000/4096,last=1), out_tlast on beats 64,128; 2 cq -> notify bytes=8192.
// - Short packet: 3 beats, last keep=0x0000_00FF -> one sq len=136 last=1; notify 136 only after cq arrives.
// - Capacity 4096, 6144B packet -> sq len 4096 last=0, FSM REARM with in_tready=0; cfg(0x9000,8KiB) -> sq 0x9000 len 2048 last=1, notify 6144.
// - MAX_OUTSTANDING=2, cq withheld -> 3rd chunk's first beat stalls (in_tready=0); one cq -> stream resumes next cycle.
// - N=4, all streams in REQ the same cycle, sq_ready=1 -> grants 0,1,2,3 on consecutive cycles; hold sq_ready=0 -> sq_strm/sq_vaddr stable.
// - Assert rst_n=0 mid-chunk with 2 outstanding -> next cycle all valids 0, cfg_ready=1; later stray cq ignored; fresh packet behaves as test 1.

Source files
------------

// File: rtl/multi_stream_output_writer_if.sv
// Bus bundle for multi_stream_output_writer.
// Purpose: groups the per-stream config, input AXI4S, output AXI4S, the shared
// sq_wr request channel, the cq_wr completion channel and the notify channel.
// Ports (all flattened, stream i occupies slice i of each vector):
//   cfg_valid/cfg_ready/cfg_vaddr/cfg_bytes   per-stream buffer config
//   in_tdata/in_tkeep/in_tlast/in_tvalid/in_tready      input streams
//   out_tdata/out_tkeep/out_tlast/out_tvalid/out_tready output streams
//   sq_valid/sq_ready/sq_vaddr/sq_len/sq_strm/sq_last   write requests
//   cq_valid/cq_strm                                    completions
//   notify_valid/notify_ready/notify_strm/notify_bytes  packet-done notify
// Modport master is the writer side, slave is the surrounding shell/pipeline.
interface multi_stream_output_writer_if #(
    parameter int N_STREAMS = 4,
    parameter int DATA_W    = 512,
    parameter int SID_W     = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic [N_STREAMS-1:0]        cfg_valid;
    logic [N_STREAMS-1:0]        cfg_ready;
    logic [N_STREAMS*48-1:0]     cfg_vaddr;
    logic [N_STREAMS*32-1:0]     cfg_bytes;

    logic [N_STREAMS*DATA_W-1:0] in_tdata;
    logic [N_STREAMS*KEEP_W-1:0] in_tkeep;
    logic [N_STREAMS-1:0]        in_tlast;
    logic [N_STREAMS-1:0]        in_tvalid;
    logic [N_STREAMS-1:0]        in_tready;

    logic [N_STREAMS*DATA_W-1:0] out_tdata;
    logic [N_STREAMS*KEEP_W-1:0] out_tkeep;
    logic [N_STREAMS-1:0]        out_tlast;
    logic [N_STREAMS-1:0]        out_tvalid;
    logic [N_STREAMS-1:0]        out_tready;

    logic                        sq_valid;
    logic                        sq_ready;
    logic [47:0]                 sq_vaddr;
    logic [27:0]                 sq_len;
    logic [SID_W-1:0]            sq_strm;
    logic                        sq_last;

    logic                        cq_valid;
    logic [SID_W-1:0]            cq_strm;

    logic                        notify_valid;
    logic                        notify_ready;
    logic [SID_W-1:0]            notify_strm;
    logic [31:0]                 notify_bytes;

    modport master (
        input  cfg_valid, cfg_vaddr, cfg_bytes,
        input  in_tdata, in_tkeep, in_tlast, in_tvalid,
        input  out_tready, sq_ready, cq_valid, cq_strm, notify_ready,
        output cfg_ready, in_tready,
        output out_tdata, out_tkeep, out_tlast, out_tvalid,
        output sq_valid, sq_vaddr, sq_len, sq_strm, sq_last,
        output notify_valid, notify_strm, notify_bytes
    );

    modport slave (
        output cfg_valid, cfg_vaddr, cfg_bytes,
        output in_tdata, in_tkeep, in_tlast, in_tvalid,
        output out_tready, sq_ready, cq_valid, cq_strm, notify_ready,
        input  cfg_ready, in_tready,
        input  out_tdata, out_tkeep, out_tlast, out_tvalid,
        input  sq_valid, sq_vaddr, sq_len, sq_strm, sq_last,
        input  notify_valid, notify_strm, notify_bytes
    );
endinterface

// File: rtl/multi_stream_output_writer.sv
// multi_stream_output_writer
// Purpose: N_STREAMS independent AXI4S output streams, each written into a host
// buffer in chunks of at most TRANSFER_BYTES. Every chunk produces one sq_wr
// request (round-robin across streams), completions on cq_wr are counted per
// stream (at most MAX_OUTSTANDING in flight), and each finished packet produces
// one notify carrying its total byte count once all its writes have completed.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    multi_stream_output_writer_if.master (config, in/out streams,
//          sq request, cq completion, notify)
module multi_stream_output_writer #(
    parameter int N_STREAMS       = 4,
    parameter int DATA_W          = 512,
    parameter int TRANSFER_BYTES  = 4096,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SID_W           = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_stream_output_writer_if.master bus
);
    localparam int KEEP_W  = DATA_W / 8;
    localparam int CHUNK_W = $clog2(TRANSFER_BYTES) + 1;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PC_W    = $clog2(KEEP_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_STREAM, S_REQ, S_REARM, S_DRAIN, S_NOTIFY
    } state_t;

    state_t               state_q    [N_STREAMS];
    state_t               state_d    [N_STREAMS];
    logic [47:0]          addr_q     [N_STREAMS];
    logic [31:0]          cap_q      [N_STREAMS];
    logic [CHUNK_W-1:0]   chunk_q    [N_STREAMS];
    logic [31:0]          total_q    [N_STREAMS];
    logic [OUT_W-1:0]     outst_q    [N_STREAMS];
    logic [N_STREAMS-1:0] plast_q;

    logic [KEEP_W-1:0]    keep_v     [N_STREAMS];
    logic [31:0]          next_chunk [N_STREAMS];
    logic [N_STREAMS-1:0] stall, chunk_end, cfg_open, cfg_hs, beat_hs;
    logic [N_STREAMS-1:0] sq_req, nt_req, sq_take, nt_take, cq_hit;

    logic                 sq_any, sq_hs, sq_lock_q;
    logic [SID_W-1:0]     sq_gnt, sq_ptr_q, sq_lock_id_q;
    logic                 nt_any, nt_hs, nt_lock_q;
    logic [SID_W-1:0]     nt_gnt, nt_ptr_q, nt_lock_id_q;

    function automatic logic [PC_W-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [PC_W-1:0] c;
        c = '0;
        for (int b = 0; b < KEEP_W; b++) c = c + PC_W'(k[b]);
        return c;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // First requester at or after ptr, wrapping.
    function automatic logic [SID_W-1:0] rr_pick(input logic [N_STREAMS-1:0] req,
                                                 input logic [SID_W-1:0] ptr);
        logic [SID_W-1:0] g;
        logic             found;
        int               idx;
        g     = ptr;
        found = 1'b0;
        for (int k = 0; k < N_STREAMS; k++) begin
            idx = (int'(ptr) + k) % N_STREAMS;
            if (!found && req[idx]) begin
                g     = SID_W'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [SID_W-1:0] rr_next(input logic [SID_W-1:0] g);
        return (int'(g) == N_STREAMS - 1) ? '0 : SID_W'(int'(g) + 1);
    endfunction

    // Per-stream datapath: STREAM is a combinational pass-through gated by
    // the outstanding limit; everything else holds the stream closed.
    always_comb begin
        bus.cfg_ready  = '0;
        bus.in_tready  = '0;
        bus.out_tvalid = '0;
        bus.out_tlast  = '0;
        bus.out_tdata  = '0;
        bus.out_tkeep  = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            keep_v[i]     = bus.in_tkeep[i*KEEP_W +: KEEP_W];
            next_chunk[i] = 32'(chunk_q[i]) + 32'(popcount(keep_v[i]));
            // A new chunk may not start while the stream is at its in-flight limit.
            stall[i]      = (outst_q[i] == OUT_W'(MAX_OUTSTANDING)) && (chunk_q[i] == '0);
            chunk_end[i]  = (next_chunk[i] == 32'(TRANSFER_BYTES)) ||
                            (next_chunk[i] == cap_q[i]) || bus.in_tlast[i];
            cfg_open[i]   = (state_q[i] == S_IDLE) || (state_q[i] == S_REARM);
            cfg_hs[i]     = cfg_open[i] && bus.cfg_valid[i];
            beat_hs[i]    = (state_q[i] == S_STREAM) && bus.in_tvalid[i] &&
                            bus.out_tready[i] && !stall[i];
            sq_req[i]     = (state_q[i] == S_REQ);
            nt_req[i]     = (state_q[i] == S_NOTIFY);
            cq_hit[i]     = bus.cq_valid && (bus.cq_strm == SID_W'(i)) && (outst_q[i] != '0);
            bus.cfg_ready[i] = cfg_open[i];
            if (state_q[i] == S_STREAM) begin
                bus.in_tready[i]  = bus.out_tready[i] && !stall[i];
                bus.out_tvalid[i] = bus.in_tvalid[i] && !stall[i];
                bus.out_tlast[i]  = chunk_end[i];
                bus.out_tdata[i*DATA_W +: DATA_W] = bus.in_tdata[i*DATA_W +: DATA_W];
                bus.out_tkeep[i*KEEP_W +: KEEP_W] = keep_v[i];
            end
        end
    end

    // Arbiters: a grant stays locked while its request is stalled by !ready.
    always_comb begin
        sq_any = |sq_req;
        sq_gnt = sq_lock_q ? sq_lock_id_q : rr_pick(sq_req, sq_ptr_q);
        sq_hs  = sq_any && bus.sq_ready;
        nt_any = |nt_req;
        nt_gnt = nt_lock_q ? nt_lock_id_q : rr_pick(nt_req, nt_ptr_q);
        nt_hs  = nt_any && bus.notify_ready;
        for (int i = 0; i < N_STREAMS; i++) begin
            sq_take[i] = sq_hs && (sq_gnt == SID_W'(i));
            nt_take[i] = nt_hs && (nt_gnt == SID_W'(i));
        end
        bus.sq_valid     = sq_any;
        bus.sq_vaddr     = sq_any ? addr_q[sq_gnt] : '0;
        bus.sq_len       = sq_any ? 28'(chunk_q[sq_gnt]) : '0;
        bus.sq_strm      = sq_any ? sq_gnt : '0;
        bus.sq_last      = sq_any && plast_q[sq_gnt];
        bus.notify_valid = nt_any;
        bus.notify_strm  = nt_any ? nt_gnt : '0;
        bus.notify_bytes = nt_any ? total_q[nt_gnt] : '0;
    end

    always_comb begin
        for (int i = 0; i < N_STREAMS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:   if (cfg_hs[i]) state_d[i] = S_STREAM;
                S_STREAM: if (beat_hs[i] && chunk_end[i]) state_d[i] = S_REQ;
                S_REQ: begin
                    if (sq_take[i]) begin
                        if (plast_q[i])                          state_d[i] = S_DRAIN;
                        else if (cap_q[i] == 32'(chunk_q[i]))    state_d[i] = S_REARM;
                        else                                     state_d[i] = S_STREAM;
                    end
                end
                S_REARM:  if (cfg_hs[i]) state_d[i] = S_STREAM;
                S_DRAIN:  if (outst_q[i] == '0) state_d[i] = S_NOTIFY;
                S_NOTIFY: if (nt_take[i]) state_d[i] = S_IDLE;
                default:  state_d[i] = S_IDLE;
            endcase
        end
    end

    // Control state: FSMs, counters, arbiter pointers and locks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STREAMS; i++) begin
                state_q[i] <= S_IDLE;
                chunk_q[i] <= '0;
                total_q[i] <= '0;
                outst_q[i] <= '0;
            end
            plast_q      <= '0;
            sq_ptr_q     <= '0;
            sq_lock_q    <= 1'b0;
            sq_lock_id_q <= '0;
            nt_ptr_q     <= '0;
            nt_lock_q    <= 1'b0;
            nt_lock_id_q <= '0;
        end else begin
            for (int i = 0; i < N_STREAMS; i++) begin
                state_q[i] <= state_d[i];
                if (cfg_hs[i] && state_q[i] == S_IDLE) begin
                    chunk_q[i] <= '0;
                    total_q[i] <= '0;
                end else if (beat_hs[i]) begin
                    chunk_q[i] <= CHUNK_W'(next_chunk[i]);
                end else if (sq_take[i]) begin
                    chunk_q[i] <= '0;
                    total_q[i] <= sat_add32(total_q[i], 32'(chunk_q[i]));
                end
                if (beat_hs[i] && chunk_end[i]) plast_q[i] <= bus.in_tlast[i];
                // Issue and completion in the same cycle cancel out.
                outst_q[i] <= outst_q[i] + OUT_W'(sq_take[i]) - OUT_W'(cq_hit[i]);
            end
            if (sq_hs) sq_ptr_q <= rr_next(sq_gnt);
            sq_lock_q    <= sq_any && !bus.sq_ready;
            sq_lock_id_q <= sq_gnt;
            if (nt_hs) nt_ptr_q <= rr_next(nt_gnt);
            nt_lock_q    <= nt_any && !bus.notify_ready;
            nt_lock_id_q <= nt_gnt;
        end
    end

    // Buffer address/capacity are loaded on config before use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_STREAMS; i++) begin
            if (cfg_hs[i]) begin
                addr_q[i] <= bus.cfg_vaddr[i*48 +: 48];
                cap_q[i]  <= bus.cfg_bytes[i*32 +: 32];
            end else if (sq_take[i]) begin
                addr_q[i] <= addr_q[i] + 48'(chunk_q[i]);
                cap_q[i]  <= cap_q[i] - 32'(chunk_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_STREAMS; i++) begin
                if (beat_hs[i] && !bus.in_tlast[i])
                    assert (keep_v[i] == '1);
                if (beat_hs[i] && bus.in_tlast[i])
                    assert ((keep_v[i] & (keep_v[i] + KEEP_W'(1))) == '0);
                if (cfg_hs[i])
                    assert ((bus.cfg_bytes[i*32 +: 32] != 32'd0) &&
                            ((bus.cfg_bytes[i*32 +: 32] % 32'(KEEP_W)) == 32'd0));
            end
            if (bus.cq_valid)
                assert (outst_q[bus.cq_strm] != '0);
        end
    end
endmodule

// File: tb/tb_multi_stream_output_writer.sv
module tb_multi_stream_output_writer;
    localparam int N  = 4;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_stream_output_writer_if #(.N_STREAMS(N), .DATA_W(DW)) bus ();

    multi_stream_output_writer #(
        .N_STREAMS(N), .DATA_W(DW), .TRANSFER_BYTES(4096), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int pt_err = 0;
    int cyc = 0;

    logic [47:0] sq_addr_q [$];
    logic [27:0] sq_len_q  [$];
    int          sq_strm_q [$];
    logic        sq_last_q [$];
    int          sq_cyc_q  [$];
    int          nt_strm_q [$];
    logic [31:0] nt_bytes_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n && bus.sq_valid && bus.sq_ready) begin
            sq_addr_q.push_back(bus.sq_vaddr);
            sq_len_q.push_back(bus.sq_len);
            sq_strm_q.push_back(int'(bus.sq_strm));
            sq_last_q.push_back(bus.sq_last);
            sq_cyc_q.push_back(cyc);
        end
        if (rst_n && bus.notify_valid && bus.notify_ready) begin
            nt_strm_q.push_back(int'(bus.notify_strm));
            nt_bytes_q.push_back(bus.notify_bytes);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        sq_addr_q.delete(); sq_len_q.delete(); sq_strm_q.delete();
        sq_last_q.delete(); sq_cyc_q.delete();
        nt_strm_q.delete(); nt_bytes_q.delete();
    endtask

    task automatic do_cfg(input int s, input logic [47:0] va, input logic [31:0] nb);
        int n = 0;
        bus.cfg_valid[s] = 1'b1;
        bus.cfg_vaddr[s*48 +: 48] = va;
        bus.cfg_bytes[s*32 +: 32] = nb;
        @(negedge clk);
        while (!bus.cfg_ready[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_ready_wait", 64'(bus.cfg_ready[s]), 64'd1);
        step();
        bus.cfg_valid[s] = 1'b0;
    endtask

    task automatic beat(input int s, input logic [KW-1:0] keep, input logic last, output logic tl);
        int n = 0;
        bus.in_tvalid[s] = 1'b1;
        bus.in_tkeep[s*KW +: KW] = keep;
        bus.in_tlast[s] = last;
        bus.in_tdata[s*DW +: DW] = {16{$urandom()}};
        @(negedge clk);
        while (!bus.in_tready[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("in_tready_wait", 64'd0, 64'd1);
        tl = bus.out_tlast[s];
        if (bus.out_tdata[s*DW +: DW] !== bus.in_tdata[s*DW +: DW] ||
            bus.out_tkeep[s*KW +: KW] !== keep || bus.out_tvalid[s] !== 1'b1)
            pt_err++;
        step();
        bus.in_tvalid[s] = 1'b0;
        bus.in_tlast[s] = 1'b0;
    endtask

    task automatic wait_sq(input string tg, input int cnt);
        int n = 0;
        while (sq_len_q.size() < cnt && n < 500) begin
            step();
            n++;
        end
        chk({tg, "_sq_count"}, 64'(sq_len_q.size()), 64'(cnt));
    endtask

    task automatic wait_nt(input string tg, input int cnt);
        int n = 0;
        while (nt_bytes_q.size() < cnt && n < 500) begin
            step();
            n++;
        end
        chk({tg, "_nt_count"}, 64'(nt_bytes_q.size()), 64'(cnt));
    endtask

    task automatic cq_pulse(input int s);
        bus.cq_valid = 1'b1;
        bus.cq_strm = SW'(s);
        step();
        bus.cq_valid = 1'b0;
    endtask

    task automatic chk_sq(input string tg, input int k, input logic [47:0] a,
                          input logic [27:0] l, input int s, input logic lst);
        if (sq_len_q.size() > k) begin
            chk({tg, "_sq_addr"}, 64'(sq_addr_q[k]), 64'(a));
            chk({tg, "_sq_len"},  64'(sq_len_q[k]),  64'(l));
            chk({tg, "_sq_strm"}, 64'(sq_strm_q[k]), 64'(s));
            chk({tg, "_sq_last"}, 64'(sq_last_q[k]), 64'(lst));
        end
    endtask

    task automatic run_t1(input string tg);
        logic tl;
        int tl_cnt = 0;
        int tl_bad = 0;
        clr();
        pt_err = 0;
        do_cfg(0, 48'h1000, 32'd65536);
        for (int b = 1; b <= 128; b++) begin
            beat(0, '1, (b == 128), tl);
            if (tl) begin
                tl_cnt++;
                if (b != 64 && b != 128) tl_bad++;
            end
        end
        chk({tg, "_tlast_cnt"}, 64'(tl_cnt), 64'd2);
        chk({tg, "_tlast_pos"}, 64'(tl_bad), 64'd0);
        chk({tg, "_passthru"}, 64'(pt_err), 64'd0);
        wait_sq(tg, 2);
        chk_sq({tg, "0"}, 0, 48'h1000, 28'd4096, 0, 1'b0);
        chk_sq({tg, "1"}, 1, 48'h2000, 28'd4096, 0, 1'b1);
        repeat (5) step();
        chk({tg, "_no_early_notify"}, 64'(nt_bytes_q.size()), 64'd0);
        cq_pulse(0);
        cq_pulse(0);
        wait_nt(tg, 1);
        if (nt_bytes_q.size() > 0) begin
            chk({tg, "_nt_bytes"}, 64'(nt_bytes_q[0]), 64'd8192);
            chk({tg, "_nt_strm"}, 64'(nt_strm_q[0]), 64'd0);
        end
        step();
        chk({tg, "_idle_cfg_ready"}, 64'(bus.cfg_ready[0]), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tl;
        bus.cfg_valid = '0; bus.cfg_vaddr = '0; bus.cfg_bytes = '0;
        bus.in_tdata = '0; bus.in_tkeep = '0; bus.in_tlast = '0; bus.in_tvalid = '1;
        bus.out_tready = '1; bus.sq_ready = 1'b1; bus.cq_valid = 1'b0; bus.cq_strm = '0;
        bus.notify_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'hF);
        chk("rst_in_tready", 64'(bus.in_tready), 64'h0);
        chk("rst_out_tvalid", 64'(bus.out_tvalid), 64'h0);
        chk("rst_sq_valid", 64'(bus.sq_valid), 64'h0);
        chk("rst_notify_valid", 64'(bus.notify_valid), 64'h0);
        chk("rst_out_tdata", 64'(bus.out_tdata[63:0]), 64'h0);
        step();
        bus.in_tvalid = '0;
        rst_n = 1'b1;
        step();

        // Two full chunks, notify after both completions
        run_t1("t1");

        // Short packet
        clr();
        do_cfg(0, 48'h4000, 32'd65536);
        beat(0, '1, 1'b0, tl);
        beat(0, '1, 1'b0, tl);
        beat(0, 64'h0000_0000_0000_00FF, 1'b1, tl);
        chk("t2_tlast", 64'(tl), 64'd1);
        wait_sq("t2", 1);
        chk_sq("t2", 0, 48'h4000, 28'd136, 0, 1'b1);
        repeat (6) step();
        chk("t2_no_early_notify", 64'(nt_bytes_q.size()), 64'd0);
        cq_pulse(0);
        wait_nt("t2", 1);
        if (nt_bytes_q.size() > 0) chk("t2_nt_bytes", 64'(nt_bytes_q[0]), 64'd136);

        // Capacity exhaustion and rearm
        clr();
        do_cfg(0, 48'h8000, 32'd4096);
        for (int b = 1; b <= 64; b++) beat(0, '1, 1'b0, tl);
        chk("t3_cap_tlast", 64'(tl), 64'd1);
        wait_sq("t3a", 1);
        chk_sq("t3a", 0, 48'h8000, 28'd4096, 0, 1'b0);
        bus.in_tvalid[0] = 1'b1;
        bus.in_tkeep[0 +: KW] = '1;
        @(negedge clk);
        chk("t3_rearm_in_tready", 64'(bus.in_tready[0]), 64'd0);
        chk("t3_rearm_cfg_ready", 64'(bus.cfg_ready[0]), 64'd1);
        step();
        bus.in_tvalid[0] = 1'b0;
        do_cfg(0, 48'h9000, 32'd8192);
        for (int b = 1; b <= 32; b++) beat(0, '1, (b == 32), tl);
        wait_sq("t3b", 2);
        chk_sq("t3b", 1, 48'h9000, 28'd2048, 0, 1'b1);
        cq_pulse(0);
        cq_pulse(0);
        wait_nt("t3", 1);
        if (nt_bytes_q.size() > 0) chk("t3_nt_bytes", 64'(nt_bytes_q[0]), 64'd6144);

        // Outstanding limit stall and resume
        clr();
        do_cfg(0, 48'h20000, 32'd65536);
        for (int b = 1; b <= 128; b++) beat(0, '1, 1'b0, tl);
        wait_sq("t4a", 2);
        bus.in_tvalid[0] = 1'b1;
        bus.in_tkeep[0 +: KW] = '1;
        bus.in_tlast[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_in_tready", 64'(bus.in_tready[0]), 64'd0);
            chk("t4_stall_out_tvalid", 64'(bus.out_tvalid[0]), 64'd0);
            step();
        end
        bus.cq_valid = 1'b1;
        bus.cq_strm = '0;
        @(negedge clk);
        chk("t4_cq_cycle_in_tready", 64'(bus.in_tready[0]), 64'd0);
        step();
        bus.cq_valid = 1'b0;
        @(negedge clk);
        chk("t4_resume_in_tready", 64'(bus.in_tready[0]), 64'd1);
        step();
        bus.in_tvalid[0] = 1'b0;
        bus.in_tlast[0] = 1'b0;
        wait_sq("t4b", 3);
        chk_sq("t4b", 2, 48'h22000, 28'd64, 0, 1'b1);
        cq_pulse(0);
        cq_pulse(0);
        wait_nt("t4", 1);
        if (nt_bytes_q.size() > 0) chk("t4_nt_bytes", 64'(nt_bytes_q[0]), 64'd8256);

        // Round-robin across four streams, grant held under !sq_ready
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        clr();
        for (int s = 0; s < N; s++) begin
            bus.cfg_valid[s] = 1'b1;
            bus.cfg_vaddr[s*48 +: 48] = 48'h100000 * (s + 1);
            bus.cfg_bytes[s*32 +: 32] = 32'd65536;
        end
        step();
        bus.cfg_valid = '0;
        bus.sq_ready = 1'b0;
        for (int s = 0; s < N; s++) begin
            bus.in_tvalid[s] = 1'b1;
            bus.in_tkeep[s*KW +: KW] = 64'hFF;
            bus.in_tlast[s] = 1'b1;
        end
        @(negedge clk);
        chk("t5_all_in_tready", 64'(bus.in_tready), 64'hF);
        step();
        bus.in_tvalid = '0;
        bus.in_tlast = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(bus.sq_valid), 64'd1);
            chk("t5_hold_strm", 64'(bus.sq_strm), 64'd0);
            chk("t5_hold_vaddr", 64'(bus.sq_vaddr), 64'h100000);
            step();
        end
        bus.sq_ready = 1'b1;
        wait_sq("t5", 4);
        for (int k = 0; k < 4; k++) begin
            if (sq_len_q.size() > k) begin
                chk("t5_gnt_strm", 64'(sq_strm_q[k]), 64'(k));
                chk("t5_gnt_vaddr", 64'(sq_addr_q[k]), 64'h100000 * (k + 1));
                chk("t5_gnt_len", 64'(sq_len_q[k]), 64'd8);
                chk("t5_gnt_cycle", 64'(sq_cyc_q[k] - sq_cyc_q[0]), 64'(k));
            end
        end
        for (int s = 0; s < N; s++) cq_pulse(s);
        wait_nt("t5", 4);
        for (int k = 0; k < 4; k++) begin
            if (nt_bytes_q.size() > k) begin
                chk("t5_nt_strm", 64'(nt_strm_q[k]), 64'(k));
                chk("t5_nt_bytes", 64'(nt_bytes_q[k]), 64'd8);
            end
        end

        // Reset mid-chunk with two writes in flight
        clr();
        do_cfg(0, 48'h1000, 32'd65536);
        for (int b = 1; b <= 64; b++) beat(0, '1, 1'b0, tl);
        wait_sq("t6a", 1);
        do_cfg(1, 48'h7000, 32'd4096);
        beat(1, 64'hFF, 1'b1, tl);
        wait_sq("t6b", 2);
        for (int b = 1; b <= 10; b++) beat(0, '1, 1'b0, tl);
        bus.in_tvalid[0] = 1'b1;
        bus.in_tkeep[0 +: KW] = '1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_out_tvalid", 64'(bus.out_tvalid), 64'h0);
        chk("t6_rst_in_tready", 64'(bus.in_tready), 64'h0);
        chk("t6_rst_sq_valid", 64'(bus.sq_valid), 64'h0);
        chk("t6_rst_notify_valid", 64'(bus.notify_valid), 64'h0);
        chk("t6_rst_cfg_ready", 64'(bus.cfg_ready), 64'hF);
        step();
        rst_n = 1'b1;
        bus.in_tvalid = '0;
        repeat (10) step();
        chk("t6_no_partial_sq", 64'(sq_len_q.size()), 64'd2);
        chk("t6_no_partial_notify", 64'(nt_bytes_q.size()), 64'd0);
        run_t1("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
